// File: rtl/sobel_line_scheduler_pkg.sv
// Shared state encoding, default geometry and bank helpers for the
// Sobel line scheduler and its position counter.
package sobel_line_scheduler_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int SRC_MIN_DEF  = 6;
   localparam int DST_MAX_DEF  = 1000;
   localparam int CNT_W_DEF    = 10;
   localparam int ROW_W        = 9;
   localparam int BANK_W       = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PRIME,
      ST_RUN,
      ST_DONE
   } state_t;

   typedef logic [BANK_W-1:0] bank_t;

   // Three line banks rotate 0 -> 1 -> 2 -> 0.
   function automatic bank_t next_bank(input bank_t b);
      return (b == bank_t'(2)) ? bank_t'(0) : b + bank_t'(1);
   endfunction

endpackage

// File: rtl/sobel_pos_counter.sv
// Column/row/bank position of the next pixel to be popped.
// Ports: clk_w, rst, clr (sync clear), adv (one pixel popped),
//        col/row/bank (position), col_last/row_last (at line/frame edge).
module sobel_pos_counter
   import sobel_line_scheduler_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             clk_w,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output bank_t            bank,
   output logic             col_last,
   output logic             row_last
);

   localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(H_ACTIVE - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE - 1);

   assign col_last = (col == COL_MAX);
   assign row_last = (row == ROW_MAX);

   always_ff @(posedge clk_w or posedge rst) begin
      if (rst) begin
         col  <= '0;
         row  <= '0;
         bank <= '0;
      end else if (clr) begin
         col  <= '0;
         row  <= '0;
         bank <= '0;
      end else if (adv) begin
         if (col_last) begin
            col <= '0;
            if (row_last) begin
               row  <= '0;
               bank <= '0;
            end else begin
               row  <= row + ROW_W'(1);
               bank <= next_bank(bank);
            end
         end else begin
            col <= col + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sobel_line_scheduler.sv
// Sequencer for the Sobel datapath: pops camera FIFO, locks to SOF,
// tracks position, rotates line banks and gates output FIFO pushes.
// Ports: clk_w, rst, enable, src_count/src_sof (camera FIFO head),
//        dst_count (output FIFO fill), rd_en, pix_valid, wr_bank,
//        rd_bank, wr_addr, out_valid, row, frame_done, frame_abort, busy.
module sobel_line_scheduler
   import sobel_line_scheduler_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int SRC_MIN  = SRC_MIN_DEF,
   parameter int DST_MAX  = DST_MAX_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             clk_w,
   input  logic             rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] src_count,
   input  logic             src_sof,
   input  logic [CNT_W-1:0] dst_count,
   output logic             rd_en,
   output logic             pix_valid,
   output logic [1:0]       wr_bank,
   output logic [1:0]       rd_bank,
   output logic [CNT_W-1:0] wr_addr,
   output logic             out_valid,
   output logic [8:0]       row,
   output logic             frame_done,
   output logic             frame_abort,
   output logic             busy
);

   localparam logic [CNT_W-1:0] SRC_MIN_C = CNT_W'(SRC_MIN);
   localparam logic [CNT_W-1:0] DST_MAX_C = CNT_W'(DST_MAX);

   state_t           state, state_n;
   logic             pop_ok, clr, adv, abort;
   logic [CNT_W-1:0] pos_col;
   logic [ROW_W-1:0] pos_row;
   bank_t            pos_bank;
   logic             col_last, row_last;

   sobel_pos_counter #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .CNT_W    (CNT_W)
   ) u_pos (
      .clk_w    (clk_w),
      .rst      (rst),
      .clr      (clr),
      .adv      (adv),
      .col      (pos_col),
      .row      (pos_row),
      .bank     (pos_bank),
      .col_last (col_last),
      .row_last (row_last)
   );

   assign pop_ok = (src_count >= SRC_MIN_C) && (dst_count <= DST_MAX_C);

   always_ff @(posedge clk_w or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // An SOF word is never popped outside position (0,0): in SYNC it
   // starts the frame, mid-frame it aborts and restarts priming.
   always_comb begin
      state_n = state;
      rd_en   = 1'b0;
      clr     = 1'b0;
      adv     = 1'b0;
      abort   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (enable) state_n = ST_SYNC;
         end
         ST_SYNC: begin
            if (src_sof) begin
               state_n = ST_PRIME;
               clr     = 1'b1;
            end else begin
               rd_en = pop_ok;
            end
         end
         ST_PRIME, ST_RUN: begin
            if (src_sof && (pos_col != '0 || pos_row != '0)) begin
               abort   = 1'b1;
               clr     = 1'b1;
               state_n = ST_PRIME;
            end else if (pop_ok) begin
               rd_en = 1'b1;
               adv   = 1'b1;
               if (col_last) begin
                  if (state == ST_PRIME && pos_row == ROW_W'(1))
                     state_n = ST_RUN;
                  else if (state == ST_RUN && row_last)
                     state_n = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_n = enable ? ST_SYNC : ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Pixel-side outputs line up with the datapath's registered pixel.
   always_ff @(posedge clk_w or posedge rst) begin
      if (rst) begin
         pix_valid   <= 1'b0;
         out_valid   <= 1'b0;
         frame_abort <= 1'b0;
         wr_bank     <= 2'd0;
         rd_bank     <= 2'd1;
         wr_addr     <= '0;
         row         <= '0;
      end else begin
         pix_valid   <= adv;
         out_valid   <= adv && (state == ST_RUN);
         frame_abort <= abort;
         if (adv) begin
            wr_addr <= pos_col;
            row     <= pos_row;
            wr_bank <= pos_bank;
            rd_bank <= next_bank(pos_bank);
         end
      end
   end

   assign frame_done = (state == ST_DONE);
   assign busy       = (state == ST_PRIME) || (state == ST_RUN);

endmodule

// File: tb/tb_sobel_line_scheduler.sv
// Scoreboard bench for sobel_line_scheduler on a reduced 8x6 frame.
// Camera FIFO is modelled as a queue of SOF flags.
module tb_sobel_line_scheduler;

   localparam int H = 8;
   localparam int V = 6;

   typedef struct {
      int col;
      int row;
      int bank;
      int rb;
      int ov;
   } px_t;

   logic       clk_w = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic [9:0] src_count = '0;
   logic       src_sof = 1'b0;
   logic [9:0] dst_count = '0;
   logic       rd_en, pix_valid, out_valid;
   logic [1:0] wr_bank, rd_bank;
   logic [9:0] wr_addr;
   logic [8:0] row;
   logic       frame_done, frame_abort, busy;

   sobel_line_scheduler #(
      .H_ACTIVE (H),
      .V_ACTIVE (V)
   ) dut (
      .clk_w       (clk_w),
      .rst         (rst),
      .enable      (enable),
      .src_count   (src_count),
      .src_sof     (src_sof),
      .dst_count   (dst_count),
      .rd_en       (rd_en),
      .pix_valid   (pix_valid),
      .wr_bank     (wr_bank),
      .rd_bank     (rd_bank),
      .wr_addr     (wr_addr),
      .out_valid   (out_valid),
      .row         (row),
      .frame_done  (frame_done),
      .frame_abort (frame_abort),
      .busy        (busy)
   );

   always #5 clk_w = ~clk_w;

   bit  fifo[$];
   px_t sb[$];
   int  n_cmp = 0, n_bad = 0;
   int  pops = 0, first_pops = -1;
   int  pix_cnt = 0, ov_cnt = 0, fd_cnt = 0, ab_cnt = 0;
   int  last_row = -1, last_col = -1;
   int  src_force = -1;
   bit  pop_pend = 0;

   task automatic chk(string nm, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, req);
      end
   endtask

   task automatic cyc();
      @(negedge clk_w);
      #1;
   endtask

   task automatic push_junk(int n);
      for (int i = 0; i < n; i++) fifo.push_back(1'b0);
   endtask

   task automatic push_frame(int npix);
      px_t e;
      for (int i = 0; i < npix; i++) begin
         fifo.push_back(i == 0);
         e.col  = i % H;
         e.row  = i / H;
         e.bank = (i / H) % 3;
         e.rb   = (e.bank + 1) % 3;
         e.ov   = ((i / H) >= 2) ? 1 : 0;
         sb.push_back(e);
      end
   endtask

   task automatic chk_reset(string t);
      chk({t, "_pix_valid"}, int'(pix_valid), 0);
      chk({t, "_out_valid"}, int'(out_valid), 0);
      chk({t, "_wr_bank"}, int'(wr_bank), 0);
      chk({t, "_rd_bank"}, int'(rd_bank), 1);
      chk({t, "_wr_addr"}, int'(wr_addr), 0);
      chk({t, "_row"}, int'(row), 0);
      chk({t, "_frame_done"}, int'(frame_done), 0);
      chk({t, "_frame_abort"}, int'(frame_abort), 0);
      chk({t, "_busy"}, int'(busy), 0);
      chk({t, "_rd_en"}, int'(rd_en), 0);
   endtask

   // FIFO model: update head at negedge+2, sample pop just before posedge.
   initial begin
      forever begin
         @(negedge clk_w);
         #2;
         if (pop_pend) begin
            if (fifo.size() > 0) fifo.delete(0);
            pop_pend = 0;
         end
         src_sof = (fifo.size() > 0) ? fifo[0] : 1'b0;
         if (src_force >= 0)
            src_count = 10'(src_force);
         else
            src_count = 10'((fifo.size() > 1023) ? 1023 : fifo.size());
         #2;
         if (!rst && rd_en) begin
            pop_pend = 1;
            pops++;
         end
      end
   end

   // Monitor: compare every presented pixel against the scoreboard.
   always @(posedge clk_w) begin
      px_t e;
      #1;
      if (!rst) begin
         if (pix_valid) begin
            if (first_pops < 0) first_pops = pops;
            pix_cnt++;
            last_row = int'(row);
            last_col = int'(wr_addr);
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL pix_unexpected: got col=%0d row=%0d, want none",
                        wr_addr, row);
            end else begin
               e = sb.pop_front();
               n_cmp++;
               if (int'(wr_addr) != e.col || int'(row) != e.row ||
                   int'(wr_bank) != e.bank || int'(rd_bank) != e.rb ||
                   int'(out_valid) != e.ov) begin
                  n_bad++;
                  $display("FAIL pix: got c=%0d r=%0d wb=%0d rb=%0d ov=%0d, want c=%0d r=%0d wb=%0d rb=%0d ov=%0d",
                           wr_addr, row, wr_bank, rd_bank, out_valid,
                           e.col, e.row, e.bank, e.rb, e.ov);
               end
            end
         end
         if (out_valid) begin
            ov_cnt++;
            chk("out_valid_has_pix", int'(pix_valid), 1);
         end
         if (frame_done) begin
            fd_cnt++;
            chk("done_at_last_px",
                int'(pix_valid && wr_addr == 10'(H - 1) && row == 9'(V - 1)), 1);
         end
         if (frame_abort) begin
            ab_cnt++;
            chk("abort_no_pix", int'(pix_valid), 0);
         end
      end
   end

   initial begin
      int n, pb, ob, snap, bad;

      // Reset state
      #1 rst = 1'b1;
      #1 chk_reset("por");
      cyc();
      cyc();
      rst = 1'b0;
      cyc();

      // Frame 1: three junk words ahead of SOF, stalls inside RUN
      pb = pix_cnt;
      ob = ov_cnt;
      push_junk(3);
      push_frame(H * V);
      push_junk(6);
      enable = 1'b1;
      n = 0;
      while (pix_cnt - pb < 30 && n < 500) begin cyc(); n++; end
      chk("reach_run", int'(pix_cnt - pb >= 30), 1);
      chk("junk_pops_before_px", first_pops - 1, 3);

      dst_count = 10'd1001;
      bad = 0;
      snap = pix_cnt;
      for (int i = 0; i < 20; i++) begin
         cyc();
         #2;
         if (rd_en !== 1'b0) bad++;
      end
      chk("stall_rd_en_high", bad, 0);
      chk("stall_frozen", pix_cnt, snap);
      cyc();
      dst_count = 10'd1000;
      #2;
      chk("resume_at_dst_max", int'(rd_en), 1);

      cyc();
      src_force = 5;
      #2;
      chk("src_below_min", int'(rd_en), 0);
      cyc();
      src_force = 6;
      #2;
      chk("src_at_min", int'(rd_en), 1);
      cyc();
      src_force = -1;

      n = 0;
      while (fd_cnt < 1 && n < 1000) begin cyc(); n++; end
      chk("f1_done", fd_cnt, 1);
      chk("f1_pix", pix_cnt - pb, H * V);
      chk("f1_out", ov_cnt - ob, H * (V - 2));

      // Frame 2: enable dropped mid-frame is ignored until DONE
      push_frame(H * V);
      push_junk(6);
      pb = pix_cnt;
      n = 0;
      while (pix_cnt - pb < 20 && n < 500) begin cyc(); n++; end
      enable = 1'b0;
      n = 0;
      while (fd_cnt < 2 && n < 1000) begin cyc(); n++; end
      chk("f2_done", fd_cnt, 2);
      chk("f2_pix", pix_cnt - pb, H * V);
      repeat (3) cyc();
      #2;
      chk("idle_busy", int'(busy), 0);
      chk("idle_rd_en", int'(rd_en), 0);
      chk("idle_fifo_kept", fifo.size(), 6);

      // Premature SOF at row 3 col 5
      push_frame(3 * H + 5);
      push_frame(H * V);
      push_junk(6);
      enable = 1'b1;
      n = 0;
      while (fd_cnt < 3 && n < 1000) begin cyc(); n++; end
      chk("abort_frame_done", fd_cnt, 3);
      chk("abort_pulses", ab_cnt, 1);

      // Asynchronous reset mid-RUN at row 4 col 3
      push_frame(H * V);
      push_junk(6);
      n = 0;
      while (!(last_row == 4 && last_col == 3) && n < 1000) begin
         cyc();
         n++;
      end
      chk("reach_r4c3", int'(last_row == 4 && last_col == 3), 1);
      chk("busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      #1 chk_reset("mid");
      fifo.delete();
      sb.delete();
      pop_pend = 0;
      cyc();
      cyc();
      rst = 1'b0;

      // Recovery frame after reset
      push_junk(2);
      push_frame(H * V);
      push_junk(6);
      n = 0;
      while (fd_cnt < 4 && n < 1000) begin cyc(); n++; end
      chk("recover_done", fd_cnt, 4);
      repeat (3) cyc();
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
